cpu_step_ctrl: RTL

Run/step clock-enable controller for the model computer. It consumes the divided 1 Hz clock (as a data signal) and two raw front-panel buttons, and produces a single-cycle `cpu_ce` pulse in the `I_CLK` domain that advances the CPU. It supports free-run at the divided rate, single-step, and halt on CPU request, and sits between the clock divider and the CPU core.

---
 rtl/cpu_step_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// Run/step clock-enable controller: synchronises and debounces the front-panel buttons and issues cpu_ce pulses.
// Macro CPU_STEP_CNT_EN builds the step_count pulse counter; otherwise step_count is tied to zero.
module cpu_step_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 16
) (
  input  logic             I_CLK,
  input  logic             Rst,
  input  logic             slow_clk,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_count
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10
  } mode_t;

  mode_t state_q, state_d;
  logic  ce_d;

  logic slow_p0, slow_p1, slow_p2, tick;
  logic [1:0] btn_p0, btn_p1;
  logic [1:0] deb_lvl, deb_prev, press;
  logic [DEB_W-1:0] deb_cnt [2];
  logic run_press, step_press;

  // Stage p0/p1: two-flop synchronisers; p2 holds the previous slow_clk level for edge detection
  always_ff @(posedge I_CLK or negedge Rst) begin
    if (!Rst) begin
      slow_p0 <= 1'b0;
      slow_p1 <= 1'b0;
      slow_p2 <= 1'b0;
      tick    <= 1'b0;
      btn_p0  <= '0;
      btn_p1  <= '0;
    end else begin
      slow_p0 <= slow_clk;
      slow_p1 <= slow_p0;
      slow_p2 <= slow_p1;
      tick    <= slow_p1 & ~slow_p2;
      btn_p0  <= {btn_step, btn_run};
      btn_p1  <= btn_p0;
    end
  end

  // Debounce: bit 0 is run, bit 1 is step; a level change needs DEB_CYCLES consecutive samples
  always_ff @(posedge I_CLK or negedge Rst) begin
    if (!Rst) begin
      deb_lvl  <= '0;
      deb_prev <= '0;
      press    <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      deb_prev <= deb_lvl;
      press    <= deb_lvl & ~deb_prev;
      for (int i = 0; i < 2; i++) begin
        if (btn_p1[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_lvl[i] <= btn_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign run_press  = press[0];
  assign step_press = press[1];

  always_ff @(posedge I_CLK or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_HALT;
      cpu_ce  <= 1'b0;
    end else begin
      state_q <= state_d;
      cpu_ce  <= ce_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    case (state_q)
      S_HALT: begin
        // A run press while the CPU asserts halt falls through to the step check
        if (run_press && !halt_req) state_d = S_RUN;
        else if (step_press)        state_d = S_STEP;
      end
      S_RUN: begin
        if (halt_req || run_press) state_d = S_HALT;
        else if (tick)             ce_d    = 1'b1;
      end
      S_STEP: begin
        ce_d    = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  assign state = state_q;

`ifdef CPU_STEP_CNT_EN
  logic [CNT_W-1:0] step_cnt_q;

  always_ff @(posedge I_CLK or negedge Rst) begin
    if (!Rst)        step_cnt_q <= '0;
    else if (cpu_ce) step_cnt_q <= step_cnt_q + CNT_W'(1);
  end

  assign step_count = step_cnt_q;
`else
  assign step_count = '0;
`endif

endmodule
